// File: rtl/alu_input_ctrl.sv
// alu_input_ctrl: sync/debounce/edge-detect buttons and capture switch operands and opcode for the ALU.
// Define ALU_IN_DEBOUNCE_EN to include the per-button debouncers (otherwise the synchronized level is used directly).
module alu_input_ctrl #(
  parameter int NB_DATA         = 8,
  parameter int NB_OPCODE       = 6,
  parameter int NB_SW           = 8,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NB_SW-1:0]            i_sw,
  input  logic                        i_btn_op1,
  input  logic                        i_btn_op2,
  input  logic                        i_btn_opcode,
  input  logic                        i_btn_clr,
  output logic signed [NB_DATA-1:0]   o_op_1,
  output logic signed [NB_DATA-1:0]   o_op_2,
  output logic [NB_OPCODE-1:0]        o_opcode,
  output logic                        o_valid,
  output logic [2:0]                  o_loaded,
  output logic                        o_update
);
  logic [3:0] btn, sync1, sync2, db, db_d, pulse;
  logic [2:0] nxt_loaded;
  if (DEBOUNCE_CYCLES < 1 || NB_DATA > NB_SW || NB_OPCODE > NB_SW) begin : g_bad_params
    $error("alu_input_ctrl: illegal parameter combination");
  end
  assign btn = {i_btn_clr, i_btn_opcode, i_btn_op2, i_btn_op1};
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db_d  <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      db_d  <= db;
    end
`ifdef ALU_IN_DEBOUNCE_EN
  localparam int NB_CNT = $clog2(DEBOUNCE_CYCLES + 1);
  for (genvar b = 0; b < 4; b++) begin : g_db
    logic [NB_CNT-1:0] cnt;
    logic              lvl;
    // Counts consecutive clocks of disagreement; any agreement restarts the count.
    always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync2[b] == lvl) cnt <= '0;
      else if (cnt == NB_CNT'(DEBOUNCE_CYCLES - 1)) begin
        lvl <= ~lvl;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    assign db[b] = lvl;
  end
`else
  assign db = sync2;
`endif
  assign pulse      = db & ~db_d;
  assign nxt_loaded = o_loaded | pulse[2:0];
  // Clear wins over any load arriving in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n || pulse[3]) begin
      o_op_1   <= '0;
      o_op_2   <= '0;
      o_opcode <= '0;
      o_loaded <= '0;
      o_valid  <= 1'b0;
      o_update <= 1'b0;
    end else begin
      if (pulse[0]) o_op_1 <= i_sw[NB_DATA-1:0];
      if (pulse[1]) o_op_2 <= i_sw[NB_DATA-1:0];
      if (pulse[2]) o_opcode <= i_sw[NB_OPCODE-1:0];
      o_loaded <= nxt_loaded;
      o_valid  <= &nxt_loaded;
      o_update <= (|pulse[2:0]) && (&nxt_loaded);
    end
endmodule

// File: tb/tb_alu_input_ctrl.sv
// tb_alu_input_ctrl: randomized and directed checks of alu_input_ctrl against a sample-history reference model.
module tb_alu_input_ctrl;
  localparam int DC = 4;
`ifdef ALU_IN_DEBOUNCE_EN
  localparam int LAT = 2 + DC + 1;
  localparam int SINGLE_EXP = 0;
`else
  localparam int LAT = 3;
  localparam int SINGLE_EXP = 3;
`endif
  logic i_clk = 1'b0;
  logic i_rst_n;
  logic [7:0] i_sw;
  logic i_btn_op1, i_btn_op2, i_btn_opcode, i_btn_clr;
  logic signed [7:0] o_op_1, o_op_2;
  logic [5:0] o_opcode;
  logic o_valid, o_update;
  logic [2:0] o_loaded;
  int checks = 0;
  int errors = 0;
  logic [3:0] hist [16];
  logic [3:0] m_db, m_pulse;
  logic [7:0] m_op1, m_op2;
  logic [5:0] m_opc;
  logic [2:0] m_loaded;
  logic m_valid, m_upd;

  alu_input_ctrl #(.NB_DATA(8), .NB_OPCODE(6), .NB_SW(8), .DEBOUNCE_CYCLES(DC)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sw(i_sw),
    .i_btn_op1(i_btn_op1), .i_btn_op2(i_btn_op2), .i_btn_opcode(i_btn_opcode), .i_btn_clr(i_btn_clr),
    .o_op_1(o_op_1), .o_op_2(o_op_2), .o_opcode(o_opcode),
    .o_valid(o_valid), .o_loaded(o_loaded), .o_update(o_update)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [26:0] dut_vec();
    return {o_op_1, o_op_2, o_opcode, o_valid, o_loaded, o_update};
  endfunction

  function automatic logic [26:0] mdl_vec();
    return {m_op1, m_op2, m_opc, m_valid, m_loaded, m_upd};
  endfunction

  task automatic model_reset();
    foreach (hist[i]) hist[i] = '0;
    m_db = '0; m_pulse = '0; m_op1 = '0; m_op2 = '0; m_opc = '0;
    m_loaded = '0; m_valid = 1'b0; m_upd = 1'b0;
  endtask

  // Debounced level flips once the last DC synchronized samples all disagree with it.
  task automatic model_step();
    logic [2:0] nl;
    logic [3:0] nd;
    logic all_diff;
    if (m_pulse[3]) begin
      m_op1 = '0; m_op2 = '0; m_opc = '0; m_loaded = '0; m_upd = 1'b0;
    end else begin
      nl = m_loaded | m_pulse[2:0];
      if (m_pulse[0]) m_op1 = i_sw;
      if (m_pulse[1]) m_op2 = i_sw;
      if (m_pulse[2]) m_opc = i_sw[5:0];
      m_upd = (|m_pulse[2:0]) && (&nl);
      m_loaded = nl;
    end
    m_valid = &m_loaded;
    for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {i_btn_clr, i_btn_opcode, i_btn_op2, i_btn_op1};
`ifdef ALU_IN_DEBOUNCE_EN
    nd = m_db;
    for (int b = 0; b < 4; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DC; j++) if (hist[2+j][b] == m_db[b]) all_diff = 1'b0;
      if (all_diff) nd[b] = ~m_db[b];
    end
`else
    nd = hist[1];
`endif
    m_pulse = nd & ~m_db;
    m_db = nd;
  endtask

  task automatic tick(input logic [3:0] b, input logic [7:0] sw);
    {i_btn_clr, i_btn_opcode, i_btn_op2, i_btn_op1} = b;
    i_sw = sw;
    @(posedge i_clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    {i_btn_clr, i_btn_opcode, i_btn_op2, i_btn_op1} = '0;
    i_sw = '0;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if (dut_vec() !== 27'd0) begin errors++; $display("FAIL reset_hold: dut=%h expected=0", dut_vec()); end
    i_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(4'b0000, 8'($urandom));
      checks++;
      if (dut_vec() !== 27'd0) begin errors++; $display("FAIL reset_idle cycle %0d: dut=%h expected=0", i, dut_vec()); end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] pat [21];
    for (int i = 0; i < 21; i++) pat[i] = (i < 3 || (i >= 6 && i < 9)) ? 4'b0001 : 4'b0000;
    for (int i = 0; i < 21; i++) begin
      tick(pat[i], 8'h5A);
      checks++;
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL glitch cycle %0d: dut=%h model=%h", i, dut_vec(), mdl_vec()); end
    end
`ifdef ALU_IN_DEBOUNCE_EN
    checks++;
    if (o_loaded !== 3'b000 || o_op_1 !== 8'sh00) begin
      errors++; $display("FAIL glitch_filtered: loaded=%b op1=%h expected 000/00", o_loaded, o_op_1);
    end
`endif
  endtask

  task automatic test_load_sequence();
    int lat, ups, vt, ot;
    logic [3:0] bt [3];
    logic [7:0] sv [3];
    lat = 0; ups = 0; vt = 0; ot = 0;
    bt[0] = 4'b0001; bt[1] = 4'b0010; bt[2] = 4'b0100;
    sv[0] = 8'h05; sv[1] = 8'hFD; sv[2] = 8'h20;
    for (int p = 0; p < 3; p++)
      for (int i = 1; i <= 32; i++) begin
        tick(i <= 20 ? bt[p] : 4'b0000, sv[p]);
        checks++;
        if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL load_seq phase %0d cycle %0d: dut=%h model=%h", p, i, dut_vec(), mdl_vec()); end
        if (p == 0 && lat == 0 && o_op_1 == 8'sh05) lat = i;
        if (p == 2 && vt == 0 && o_valid) vt = i;
        if (p == 2 && ot == 0 && o_opcode == 6'h20) ot = i;
        if (o_update) ups++;
      end
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL op1_latency: got %0d edges expected %0d", lat, LAT); end
    checks++;
    if ({o_op_1, o_op_2, o_opcode, o_valid, o_loaded} !== {8'h05, 8'hFD, 6'h20, 1'b1, 3'b111}) begin
      errors++; $display("FAIL load_values: op1=%h op2=%h opc=%h valid=%b loaded=%b expected 05 fd 20 1 111", o_op_1, o_op_2, o_opcode, o_valid, o_loaded);
    end
    checks++;
    if (vt !== ot || vt == 0) begin errors++; $display("FAIL valid_with_opcode: valid at %0d opcode at %0d", vt, ot); end
    checks++;
    if (ups !== 1) begin errors++; $display("FAIL load_update_count: got %0d expected 1", ups); end
  endtask

  task automatic test_hold();
    int ups;
    logic stayed;
    ups = 0; stayed = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick(i < 50 ? 4'b0001 : 4'b0000, 8'h80);
      checks++;
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL hold cycle %0d: dut=%h model=%h", i, dut_vec(), mdl_vec()); end
      if (o_update) ups++;
      if (!o_valid) stayed = 1'b0;
    end
    checks++;
    if (ups !== 1 || o_op_1 !== -8'sd128 || !stayed) begin
      errors++; $display("FAIL hold_single_load: updates=%0d op1=%h valid_held=%b expected 1 80 1", ups, o_op_1, stayed);
    end
  endtask

  task automatic test_clear_collision();
    int ups;
    ups = 0;
    for (int i = 0; i < 24; i++) begin
      tick(i < 12 ? 4'b1010 : 4'b0000, 8'h55);
      checks++;
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL clear_collision cycle %0d: dut=%h model=%h", i, dut_vec(), mdl_vec()); end
      if (o_update) ups++;
    end
    checks++;
    if (dut_vec() !== 27'd0 || ups !== 0) begin
      errors++; $display("FAIL clear_priority: dut=%h updates=%0d expected all zero", dut_vec(), ups);
    end
  endtask

  task automatic test_reset_mid();
    tick(4'b0100, 8'h11);
    tick(4'b0100, 8'h11);
    i_rst_n = 1'b0;
    model_reset();
    #3;
    {i_btn_clr, i_btn_opcode, i_btn_op2, i_btn_op1} = '0;
    i_rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(4'b0000, 8'h11);
      checks++;
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL reset_mid cycle %0d: dut=%h model=%h", i, dut_vec(), mdl_vec()); end
    end
    checks++;
    if (o_loaded !== 3'b000 || o_opcode !== 6'h00) begin
      errors++; $display("FAIL reset_discard: loaded=%b opcode=%h expected 000/00", o_loaded, o_opcode);
    end
  endtask

  task automatic test_single_pulse();
    int n;
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(i == 1 ? 4'b0010 : 4'b0000, 8'h3C);
      checks++;
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL single_pulse cycle %0d: dut=%h model=%h", i, dut_vec(), mdl_vec()); end
      if (n == 0 && o_op_2 == 8'sh3C) n = i;
    end
    checks++;
    if (n !== SINGLE_EXP) begin errors++; $display("FAIL single_pulse_latency: got %0d expected %0d", n, SINGLE_EXP); end
  endtask

  task automatic test_random();
    logic [3:0] b;
    int len;
    for (int s = 0; s < 80; s++) begin
      b = 4'($urandom_range(0, 7));
      b[3] = ($urandom_range(0, 7) == 0);
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        tick(b, 8'($urandom));
        checks++;
        if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL random seg %0d cycle %0d: dut=%h model=%h", s, i, dut_vec(), mdl_vec()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_load_sequence();
    test_hold();
    test_clear_collision();
    test_reset_mid();
    test_single_pulse();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_input_ctrl.md
Name: alu_input_ctrl

Overview:
- Upstream operand/opcode capture stage for the Basys3 ALU.
- Takes raw board switches and push-buttons, then synchronizes, debounces and edge-detects each button.
- Each button press latches the switch value into the first operand, second operand or opcode register.
- Drives the ALU inputs from those registers, with a valid flag and LED status once all three have been loaded.

Parameters:
- NB_DATA, 8, operand width; o_op_1/o_op_2 width.
- NB_OPCODE, 6, opcode width; must be <= NB_SW.
- NB_SW, 8, switch bus width; must be >= NB_DATA.
- DEBOUNCE_CYCLES, 1000000, consecutive stable clocks required to accept a button level change (10 ms at 100 MHz); must be >= 1.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_sw  input  NB_SW  raw switch inputs; treated as quasi-static, not synchronized.
- i_btn_op1  input  1  raw button: load operand 1.
- i_btn_op2  input  1  raw button: load operand 2.
- i_btn_opcode  input  1  raw button: load opcode.
- i_btn_clr  input  1  raw button: clear all captured values.
- o_op_1  output  NB_DATA  signed operand 1 to ALU.
- o_op_2  output  NB_DATA  signed operand 2 to ALU.
- o_opcode  output  NB_OPCODE  opcode to ALU.
- o_valid  output  1  high while operand 1, operand 2 and opcode have all been loaded since reset/clear.
- o_loaded  output  3  LED status {opcode_loaded, op2_loaded, op1_loaded}.
- o_update  output  1  one-cycle pulse on the cycle a register loads while the post-load state is valid.

Behaviour:
- Reset (i_rst_n=0, asynchronous) forces:
  - o_op_1, o_op_2, o_opcode = 0; o_loaded = 3'b000; o_valid = 0; o_update = 0.
  - All synchronizer flops, debounced levels and debounce counters = 0.
  - Reset mid-debounce discards the pending press.
- Per-button pipeline (4 identical instances):
  - Two-flop synchronizer.
  - Debouncer: a counter increments each clock the synchronized level differs from the debounced level, and clears to 0 when they match. When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
  - Rising-edge detector on the debounced level gives a 1-cycle load pulse.
  - Falling edges produce nothing.
- Latency: the register updates on clock edge 2+DEBOUNCE_CYCLES+1, counted from the first edge that samples the raw button high.
- Glitches: a glitch shorter than DEBOUNCE_CYCLES clocks produces no pulse.
- Holding a button held produces exactly one pulse.
- Load actions:
  - op1 pulse: o_op_1 <= i_sw[NB_DATA-1:0], op1_loaded <= 1.
  - op2 pulse: o_op_2 <= i_sw[NB_DATA-1:0], op2_loaded <= 1.
  - opcode pulse: o_opcode <= i_sw[NB_OPCODE-1:0], opcode_loaded <= 1.
- Capture FSM, state = o_loaded:
  - Any combination is reachable; load order is free.
  - o_valid = &o_loaded, registered with the flags (same edge).
  - Reloading an already-loaded register overwrites its value; the flag stays 1.
- o_update: asserted for one cycle, the cycle after a load edge, when the resulting state has all three flags set.
- Clear pulse: all data registers and flags go to 0 and o_valid goes to 0 on the same edge.
- Simultaneous pulses:
  - Clear has priority over any load in the same cycle; the loads are dropped and o_update stays 0.
  - Multiple load pulses in the same cycle all capture the same i_sw value.
- Outputs are registered; no combinational path from i_sw or the buttons to the outputs.

Optional Feature:
- Macro: ALU_IN_DEBOUNCE_EN.
- Defined: debouncers are present as described above.
- Undefined:
  - Debouncers are omitted; the debounced level equals the synchronized level.
  - DEBOUNCE_CYCLES is ignored; latency becomes 3 edges.
  - Every synchronized rising edge produces a pulse, including bounces.
  - Used for fast simulation and for boards with hardware debouncing.

Test Plan:
- Reset then release, no buttons -> all outputs 0, o_valid=0, o_loaded=000.
- DEBOUNCE_CYCLES=4; i_sw=8'h05, press op1 for 20 clocks; i_sw=8'hFD, press op2; i_sw=8'h20, press opcode -> o_op_1=8'h05, o_op_2=8'hFD, o_opcode=6'h20. o_op_1 updates exactly 7 edges after its press. o_valid rises with the opcode load, o_update pulses once.
- DEBOUNCE_CYCLES=4; op1 button high 3 clocks, low 3, high 3 -> no load, o_op_1 stays 0, o_loaded=000.
- From the valid state, i_sw=8'h80, hold op1 50 clocks -> exactly one load, o_op_1=8'h80, o_valid stays 1, exactly one o_update pulse.
- Press clear and op2 so the debounced edges coincide -> o_loaded=000, all data 0, o_update=0. Then assert i_rst_n=0 mid-debounce of an opcode press -> no load occurs after release.
- ALU_IN_DEBOUNCE_EN undefined: single-clock op2 pulse with i_sw=8'h3C -> o_op_2=8'h3C on the 3rd edge after sampling.
